// File: rtl/multicycle_control_fsm_if.sv
// Control/bus signal bundle between the multi-cycle sequencer and the RV32I datapath.
interface multicycle_control_fsm_if;
    logic [31:0] instrCode;
    logic        busReady;
    logic        pcEn;
    logic        regFileWe;
    logic [3:0]  aluControl;
    logic        aluSrcMuxSel;
    logic        busReq;
    logic        busWe;
    logic        RFWDSrcMuxSel;
    logic        branch;
    logic        busErr;
    logic        illegalInstr;

    modport slave (
        input  instrCode, busReady,
        output pcEn, regFileWe, aluControl, aluSrcMuxSel, busReq, busWe,
               RFWDSrcMuxSel, branch, busErr, illegalInstr
    );

    modport master (
        output instrCode, busReady,
        input  pcEn, regFileWe, aluControl, aluSrcMuxSel, busReq, busWe,
               RFWDSrcMuxSel, branch, busErr, illegalInstr
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// FETCH/DECODE/EXECUTE/MEM/WB sequencer for RV32I with a variable-latency data bus
// and a MEM-state timeout that retires hung transfers with a busErr pulse.
module multicycle_control_fsm #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.slave  bus
);
    localparam int CW       = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam int TMO_LAST = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;

    logic [6:0] opc;
    logic [2:0] f3;
    logic       b30;
    logic       is_r, is_i, is_l, is_s, is_b, legal;
    logic       tmo_hit;

    assign opc   = bus.instrCode[6:0];
    assign f3    = bus.instrCode[14:12];
    assign b30   = bus.instrCode[30];
    assign is_r  = (opc == OP_R);
    assign is_i  = (opc == OP_I);
    assign is_l  = (opc == OP_L);
    assign is_s  = (opc == OP_S);
    assign is_b  = (opc == OP_B);
    assign legal = is_r | is_i | is_l | is_s | is_b;

    // Register fields and immediates are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instrCode[31], bus.instrCode[29:15], bus.instrCode[11:7]};

    assign tmo_hit = (BUS_TIMEOUT > 0) && (tmo_cnt == CW'(TMO_LAST)) && !bus.busReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        tmo_cnt_nxt       = tmo_cnt;
        bus.pcEn          = 1'b0;
        bus.regFileWe     = 1'b0;
        bus.aluControl    = 4'b0000;
        bus.aluSrcMuxSel  = 1'b0;
        bus.busReq        = 1'b0;
        bus.busWe         = 1'b0;
        bus.RFWDSrcMuxSel = 1'b0;
        bus.branch        = 1'b0;
        bus.busErr        = 1'b0;
        bus.illegalInstr  = 1'b0;

        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                bus.illegalInstr = !legal;
                state_nxt        = EXECUTE;
            end
            EXECUTE: begin
                state_nxt = FETCH;
                if (is_r) begin
                    bus.aluControl = {b30, f3};
                    bus.regFileWe  = 1'b1;
                    bus.pcEn       = 1'b1;
                end else if (is_i) begin
                    // Only SRAI carries instr[30] into the ALU op; other I-types use it as imm.
                    bus.aluControl   = ({b30, f3} == 4'b1101) ? 4'b1101 : {1'b0, f3};
                    bus.aluSrcMuxSel = 1'b1;
                    bus.regFileWe    = 1'b1;
                    bus.pcEn         = 1'b1;
                end else if (is_b) begin
                    bus.aluControl = {b30, f3};
                    bus.branch     = 1'b1;
                    bus.pcEn       = 1'b1;
                end else if (is_l || is_s) begin
                    bus.aluSrcMuxSel = 1'b1;
                    tmo_cnt_nxt      = '0;
                    state_nxt        = MEM;
                end else begin
                    bus.pcEn = 1'b1;
                end
            end
            MEM: begin
                bus.busReq       = 1'b1;
                bus.busWe        = is_s;
                bus.aluSrcMuxSel = 1'b1;
                if (bus.busReady) begin
                    bus.pcEn  = is_s;
                    state_nxt = is_s ? FETCH : WB;
                end else if (tmo_hit) begin
                    bus.busErr = 1'b1;
                    bus.pcEn   = 1'b1;
                    state_nxt  = FETCH;
                end else if (tmo_cnt != '1) begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
            end
            WB: begin
                bus.regFileWe     = 1'b1;
                bus.RFWDSrcMuxSel = 1'b1;
                bus.pcEn          = 1'b1;
                state_nxt         = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // Strobes are quiet while reset is held so a reset mid-MEM drops busReq at once.
        if (reset) begin
            bus.pcEn          = 1'b0;
            bus.regFileWe     = 1'b0;
            bus.aluControl    = 4'b0000;
            bus.aluSrcMuxSel  = 1'b0;
            bus.busReq        = 1'b0;
            bus.busWe         = 1'b0;
            bus.RFWDSrcMuxSel = 1'b0;
            bus.branch        = 1'b0;
            bus.busErr        = 1'b0;
            bus.illegalInstr  = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction strobe tallies vs hand values.
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus();
    multicycle_control_fsm #(.BUS_TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int lat, pc, rfw, rfwd, req, we, err, err_cyc, ill, ill_cyc, br;
        logic [3:0] alu_ex;
        logic       asrc_ex;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // {pcEn, regFileWe, aluSrc, busReq, busWe, RFWDSrc, branch, busErr, illegal}
    function automatic logic [8:0] strb();
        return {bus.pcEn, bus.regFileWe, bus.aluSrcMuxSel, bus.busReq, bus.busWe,
                bus.RFWDSrcMuxSel, bus.branch, bus.busErr, bus.illegalInstr};
    endfunction

    // Starts in FETCH (#1 after an edge); ready_at = MEM cycle that sees busReady (0 = never).
    task automatic run(input logic [31:0] instr, input int ready_at, output res_t r);
        int m;
        m = 0;
        r = '{default: 0};
        bus.instrCode = instr;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.busReq) begin
                m++;
                bus.busReady = (m == ready_at);
            end else begin
                bus.busReady = 1'b1;
            end
            #1;
            if (cyc == 3) begin
                r.alu_ex  = bus.aluControl;
                r.asrc_ex = bus.aluSrcMuxSel;
            end
            if (bus.busReq) r.req++;
            if (bus.busReq && bus.busWe) r.we++;
            if (bus.regFileWe) r.rfw++;
            if (bus.RFWDSrcMuxSel) r.rfwd++;
            if (bus.branch) r.br++;
            if (bus.busErr) begin r.err++; r.err_cyc = cyc; end
            if (bus.illegalInstr) begin r.ill++; r.ill_cyc = cyc; end
            if (bus.pcEn) begin r.pc++; r.lat = cyc; end
            @(posedge clk); #1;
            if (r.lat != 0) break;
        end
    endtask

    task automatic check_instr(input string tag, input logic [31:0] instr, input int ready_at,
                               input int lat, input int req, input int we, input int rfw,
                               input int rfwd, input int err, input int br,
                               input logic [3:0] alu, input logic asrc);
        res_t r;
        run(instr, ready_at, r);
        chk({tag, ".lat"}, r.lat, lat);
        chk({tag, ".pc"}, r.pc, 1);
        chk({tag, ".req"}, r.req, req);
        chk({tag, ".we"}, r.we, we);
        chk({tag, ".rfw"}, r.rfw, rfw);
        chk({tag, ".rfwd"}, r.rfwd, rfwd);
        chk({tag, ".err"}, r.err, err);
        chk({tag, ".br"}, r.br, br);
        chk({tag, ".ill"}, r.ill, 0);
        chk({tag, ".alu"}, r.alu_ex, alu);
        chk({tag, ".asrc"}, r.asrc_ex, asrc);
        if (err != 0) chk({tag, ".errcyc"}, r.err_cyc, lat);
        chk({tag, ".fetch"}, strb(), 9'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        reset = 1'b1;
        bus.instrCode = 32'h0;
        bus.busReady  = 1'b0;
        #1;
        chk("rst.hold", strb(), 9'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst.strb", strb(), 9'b0);
        chk("rst.alu", bus.aluControl, 4'b0000);

        //          tag      instr         rdy lat req we rfw rfwd err br alu      asrc
        check_instr("add",   32'h002081B3, 0,  3,  0,  0, 1,  0,   0,  0, 4'b0000, 1'b0);
        check_instr("srai",  32'h4020D093, 0,  3,  0,  0, 1,  0,   0,  0, 4'b1101, 1'b1);
        check_instr("srli",  32'h0020D093, 0,  3,  0,  0, 1,  0,   0,  0, 4'b0101, 1'b1);
        check_instr("addin", 32'hC0008093, 0,  3,  0,  0, 1,  0,   0,  0, 4'b0000, 1'b1);
        check_instr("bne",   32'h00209463, 0,  3,  0,  0, 0,  0,   0,  1, 4'b0001, 1'b0);
        check_instr("lw3",   32'h0040A283, 3,  7,  3,  0, 1,  1,   0,  0, 4'b0000, 1'b1);
        check_instr("lw1",   32'h0040A283, 1,  5,  1,  0, 1,  1,   0,  0, 4'b0000, 1'b1);
        check_instr("sw2",   32'h0020A423, 2,  5,  2,  2, 0,  0,   0,  0, 4'b0000, 1'b1);
        check_instr("swto",  32'h0020A423, 0,  19, 16, 16, 0, 0,   1,  0, 4'b0000, 1'b1);
        check_instr("sw16",  32'h0020A423, 16, 19, 16, 16, 0, 0,   0,  0, 4'b0000, 1'b1);

        run(32'h0000007F, 0, r);
        chk("ill.pulse", r.ill, 1);
        chk("ill.cyc", r.ill_cyc, 2);
        chk("ill.lat", r.lat, 3);
        chk("ill.pc", r.pc, 1);
        chk("ill.rfw", r.rfw, 0);
        chk("ill.req", r.req, 0);
        chk("ill.fetch", strb(), 9'b0);

        // Reset while an LW sits in MEM waiting on the bus.
        bus.instrCode = 32'h0040A283;
        bus.busReady  = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.busReady = 1'b0;
        #1;
        chk("rmem.inmem", strb(), 9'b001100000);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rmem.hold", strb(), 9'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rmem.after", strb(), 9'b0);
        check_instr("add2",  32'h002081B3, 0,  3,  0,  0, 1,  0,   0,  0, 4'b0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
